// File: rtl/rf_wb_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | rf_ctrl_pkg: shared widths, requester index type and bus slice helpers.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rf_ctrl_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NREG     = 32;
  localparam int NREQ_MAX = 8;
  localparam int IDW      = 3;

  typedef logic [IDW-1:0] req_idx_t;

  // Callers zero-extend their packed NREQ-wide buses to NREQ_MAX slices.
  function automatic logic [AW-1:0] rd_slice(input logic [NREQ_MAX*AW-1:0] bus,
                                             input req_idx_t i);
    logic [$clog2(NREQ_MAX*AW)-1:0] lo;
    lo = ($clog2(NREQ_MAX*AW))'(i) * ($clog2(NREQ_MAX*AW))'(AW);
    return bus[lo +: AW];
  endfunction

  function automatic logic [DW-1:0] data_slice(input logic [NREQ_MAX*DW-1:0] bus,
                                               input req_idx_t i);
    logic [$clog2(NREQ_MAX*DW)-1:0] lo;
    lo = ($clog2(NREQ_MAX*DW))'(i) * ($clog2(NREQ_MAX*DW))'(DW);
    return bus[lo +: DW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter_if: writeback requester valid/ready bus with packed slices.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = rf_ctrl_pkg::AW,
  parameter int DW   = rf_ctrl_pkg::DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );

endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr.sv
// +--------------------------------------------------------------------------+
// | rf_rr_arbiter: one-hot grant; round-robin when RF_ARB_RR_EN is defined,  |
// | fixed lowest-index priority otherwise.                       Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rf_rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic [NREQ-1:0] req,
  input  wire logic            advance,
  output logic      [NREQ-1:0] gnt,
  output req_idx_t             gnt_id
);

`ifdef RF_ARB_RR_EN

  req_idx_t ptr_q;
  req_idx_t ptr_d;
  logic     found;

  // Two passes emulate a rotated search starting at ptr+1: first the indices
  // above the pointer, then wrap around to the lowest valid index.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i > int'(ptr_q))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = req_idx_t'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = req_idx_t'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = gnt_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= req_idx_t'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

`else

  logic found;
  logic unused_rr;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = req_idx_t'(i);
      end
    end
  end

  // Fixed priority is stateless; clock, reset and advance are not needed.
  assign unused_rr = ^{clk, reset, advance};

`endif

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | rf_wb_arbiter: register-file write-port arbiter with pending-write       |
// | scoreboard. Option macro: RF_ARB_RR_EN (round-robin).        Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  wire logic            clk,
  input  wire logic            reset,
  rf_wb_arbiter_if.slave       req_if,
  output logic                 rf_we,
  output logic      [AW-1:0]   rf_waddr,
  output logic      [DW-1:0]   rf_wdata,
  output logic      [2:0]      grant_id,
  input  wire logic            resv_valid,
  input  wire logic [AW-1:0]   resv_rd,
  input  wire logic [AW-1:0]   qry_rs,
  input  wire logic [AW-1:0]   qry_rt,
  output logic                 qry_rs_busy,
  output logic                 qry_rt_busy,
  output logic      [NREG-1:0] busy_vec
);

  logic [NREQ-1:0]        gnt;
  req_idx_t               gnt_id;
  logic                   xfer;
  logic [NREQ_MAX*AW-1:0] rd_bus;
  logic [NREQ_MAX*DW-1:0] data_bus;
  logic [AW-1:0]          sel_rd;
  logic [DW-1:0]          sel_data;

  logic                   rf_we_q,    rf_we_d;
  logic [AW-1:0]          rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]          rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]        busy_q,     busy_d;

  rf_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_if.req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign req_if.req_ready = gnt;
  assign grant_id         = gnt_id;
  assign xfer             = |(req_if.req_valid & gnt);

  assign rd_bus   = (NREQ_MAX*AW)'(req_if.req_rd);
  assign data_bus = (NREQ_MAX*DW)'(req_if.req_data);
  assign sel_rd   = rd_slice(rd_bus, gnt_id);
  assign sel_data = data_slice(data_bus, gnt_id);

  // A write to r0 is accepted but never raises the write enable.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_we_d    = (sel_rd != '0);
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // Clear first, then set: a same-cycle reservation is younger and wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (resv_valid && (resv_rd != '0)) begin
      busy_d[resv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign busy_vec    = busy_q;
  assign qry_rs_busy = busy_q[qry_rs];
  assign qry_rt_busy = busy_q[qry_rt];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  grant_id;
  logic        resv_valid;
  logic [4:0]  resv_rd;
  logic [4:0]  qry_rs;
  logic [4:0]  qry_rt;
  logic        qry_rs_busy;
  logic        qry_rt_busy;
  logic [31:0] busy_vec;

  logic [4:0]  rd_a [3];
  logic [31:0] d_a  [3];
  logic [2:0]  vtab [6];
  int          etab [6];

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter_if #(.NREQ(3)) bus ();

  assign bus.req_rd   = {rd_a[2], rd_a[1], rd_a[0]};
  assign bus.req_data = {d_a[2], d_a[1], d_a[0]};

  rf_wb_arbiter #(
    .NREQ (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (bus),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .grant_id    (grant_id),
    .resv_valid  (resv_valid),
    .resv_rd     (resv_rd),
    .qry_rs      (qry_rs),
    .qry_rt      (qry_rt),
    .qry_rs_busy (qry_rs_busy),
    .qry_rt_busy (qry_rt_busy),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    resv_valid    = 1'b0;
    resv_rd       = '0;
    qry_rs        = '0;
    qry_rt        = '0;
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      rd_a[i] = 5'(10 + i);
      d_a[i]  = 32'h100 + 32'(i);
    end
`ifdef RF_ARB_RR_EN
    vtab = '{3'b111, 3'b110, 3'b101, 3'b011, 3'b110, 3'b101};
    etab = '{0, 1, 2, 0, 1, 2};
`else
    vtab = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    etab = '{0, 0, 0, 0, 0, 0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we",    32'(rf_we), 32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_busy",  busy_vec, 32'd0);
    chk("reset_qry",   32'(qry_rs_busy), 32'd0);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    step();

    // Contention
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = vtab[k];
      #1;
      chk("cont_gid",   32'(grant_id), 32'(etab[k]));
      chk("cont_ready", 32'(bus.req_ready), 32'd1 << etab[k]);
      step();
    end
    bus.req_valid = '0;
    chk("cont_last_we",    32'(rf_we), 32'd1);
    chk("cont_last_waddr", 32'(rf_waddr), 32'(10 + etab[5]));
    step();

    // Single write
    rd_a[0] = 5'd5;
    d_a[0]  = 32'hDEADBEEF;
    bus.req_valid = 3'b001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'b001);
    chk("single_gid",   32'(grant_id), 32'd0);
    step();
    bus.req_valid = '0;
    chk("single_we",    32'(rf_we), 32'd1);
    chk("single_waddr", 32'(rf_waddr), 32'd5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    chk("single_we_drop", 32'(rf_we), 32'd0);
    chk("single_hold",    rf_wdata, 32'hDEADBEEF);

    // Reserve r3, then attempt to reserve r0
    resv_valid = 1'b1;
    resv_rd    = 5'd3;
    step();
    resv_rd = 5'd0;
    step();
    resv_valid = 1'b0;
    chk("resv_r3_r0", busy_vec, 32'h0000_0008);

    // r0 write
    rd_a[1] = 5'd0;
    d_a[1]  = 32'h1234;
    bus.req_valid = 3'b010;
    #1;
    chk("r0_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    chk("r0_we",   32'(rf_we), 32'd0);
    chk("r0_busy", busy_vec, 32'h0000_0008);

    // Scoreboard lifecycle on r7
    resv_valid = 1'b1;
    resv_rd    = 5'd7;
    qry_rs     = 5'd7;
    qry_rt     = 5'd3;
    #1;
    chk("sb_no_bypass", 32'(qry_rs_busy), 32'd0);
    chk("sb_rt_busy",   32'(qry_rt_busy), 32'd1);
    step();
    resv_valid = 1'b0;
    chk("sb_c1", 32'(qry_rs_busy), 32'd1);
    step();
    chk("sb_c2", 32'(qry_rs_busy), 32'd1);
    rd_a[2] = 5'd7;
    d_a[2]  = 32'h77;
    bus.req_valid = 3'b100;
    #1;
    chk("sb_wr_ready", 32'(bus.req_ready), 32'b100);
    step();
    bus.req_valid = '0;
    chk("sb_we",     32'(rf_we), 32'd1);
    chk("sb_waddr",  32'(rf_waddr), 32'd7);
    chk("sb_wdata",  rf_wdata, 32'h77);
    chk("sb_k1",     32'(qry_rs_busy), 32'd1);
    step();
    chk("sb_k2",     32'(qry_rs_busy), 32'd0);
    chk("sb_vec",    busy_vec, 32'h0000_0008);

    // Set/clear collision on r9
    resv_valid = 1'b1;
    resv_rd    = 5'd9;
    step();
    resv_valid = 1'b0;
    chk("col_resv", busy_vec, 32'h0000_0208);
    rd_a[0] = 5'd9;
    d_a[0]  = 32'h99;
    bus.req_valid = 3'b001;
    #1;
    chk("col_ready", 32'(bus.req_ready), 32'b001);
    step();
    bus.req_valid = '0;
    resv_valid    = 1'b1;
    resv_rd       = 5'd9;
    chk("col_we",    32'(rf_we), 32'd1);
    chk("col_waddr", 32'(rf_waddr), 32'd9);
    step();
    resv_valid = 1'b0;
    chk("col_set_wins", busy_vec, 32'h0000_0208);
    step();
    chk("col_stays",    busy_vec, 32'h0000_0208);

    // Reset mid-transfer
    rd_a[1] = 5'd20;
    d_a[1]  = 32'hABCD;
    bus.req_valid = 3'b010;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'b010);
    step();
    bus.req_valid = '0;
    chk("rst_pre_we", 32'(rf_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_we", 32'(rf_we), 32'd0);
    chk("rst_busy",     busy_vec, 32'd0);
    chk("rst_waddr",    32'(rf_waddr), 32'd0);
    chk("rst_qry_rt",   32'(qry_rt_busy), 32'd0);
    reset   = 1'b0;
    rd_a[0] = 5'd21;
    bus.req_valid = 3'b111;
    #1;
    chk("rst_first_ready", 32'(bus.req_ready), 32'b001);
    chk("rst_first_gid",   32'(grant_id), 32'd0);
    step();
    bus.req_valid = '0;
    chk("rst_after_we",    32'(rf_we), 32'd1);
    chk("rst_after_waddr", 32'(rf_waddr), 32'd21);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32×32 register file. It shares the file's single write port (write enable, destination address, write data) among NREQ writeback requesters, such as the ALU, the load unit and the debug port, using a valid/ready handshake. It also keeps a pending-write scoreboard so that issue logic can stall on source registers that still have a write outstanding. It sits between the execution units and the register file and drives the register file's write-enable, destination and write-data inputs directly.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- req_rd  in  NREQ*AW  destination of requester i (slice i)
- req_data  in  NREQ*DW  write data of requester i (slice i)
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  AW  register file destination (registered)
- rf_wdata  out  DW  register file write data (registered)
- grant_id  out  3  index of requester granted this cycle; valid only when |req_ready
- resv_valid  in  1  issue stage reserves a destination
- resv_rd  in  AW  destination being reserved
- qry_rs, qry_rt  in  AW  source registers queried by issue
- qry_rs_busy, qry_rt_busy  out  1  combinational: queried register has a write pending
- busy_vec  out  32  scoreboard state; bit 0 is always 0

## Operation
- **Arbitration**: combinational over req_valid.
  - req_ready is one-hot on the selected valid requester.
  - req_ready is all-zero when no requester is valid.
  - req_ready never depends on its own requester's data.
- **Transfer**: occurs when req_valid[i] && req_ready[i]. A requester holds req_rd and req_data stable until it is granted.
- **Write register stage**: on a transfer, the write-port registers load {rf_we = (rd != 0), rf_waddr = rd, rf_wdata = data}. With no transfer, rf_we <= 0 and rf_waddr/rf_wdata hold their values.
- **Writes to r0**: accepted (ready given) and dropped. No write and no scoreboard effect.
- **Scoreboard**: 32 busy bits.
  - Set: resv_valid && resv_rd != 0 sets busy[resv_rd].
  - Clear: rf_we sets busy[rf_waddr] <= 0. This is the same edge on which the register file captures the data.
  - Simultaneous set and clear of the same register: set wins, because the new reservation is younger.
  - Reserving an already-busy register leaves it busy. There is no counting; issue logic must not reserve a busy destination (WAW is the issuer's responsibility).
- **Query outputs**: qry_rs_busy = busy_vec[qry_rs] and qry_rt_busy = busy_vec[qry_rt], computed from registered state only. There is no bypass of same-cycle resv or clear.

## Timing
- Grant to register-file write: 1 cycle. A transfer in cycle N gives rf_we high in cycle N+1, and the register holds the data from the end of N+1.
- Busy clears on the edge ending cycle N+1, so a query in cycle N+2 sees not-busy.
- Throughput: one write per cycle, sustained.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, round-robin pointer=NREQ-1 (requester 0 has highest priority first).
- req_ready, grant_id and the qry_*_busy outputs are combinational. Their reset-time values follow from the reset state.
- Reset asserted mid-operation:
  - Any pending register-stage write is discarded (rf_we forced 0).
  - All reservations are lost.
  - Requesters must re-present after reset deasserts.

## Configuration
- RF_ARB_RR_EN defined: round-robin arbitration.
  - The pointer updates to the granted index on each transfer.
  - Search order starts at pointer+1 mod NREQ.
  - The pointer holds when there is no transfer.
- RF_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - No pointer state exists.
  - Starvation of higher indices is permitted.

## Structure
- Shared package rf_ctrl_pkg holds:
  - AW, DW
  - NREG=32
  - requester-index typedef
  - the function that extracts slice i from the packed req_rd/req_data buses
- One sub-module, rf_rr_arbiter: NREQ-wide request in, one-hot grant and index out, and an advance input. It contains the pointer under RF_ARB_RR_EN and is a priority encoder otherwise.
- The scoreboard and write register stage stay in the top module.

## Test plan
- **Single write**: reset, then req_valid=001, rd=5, data=0xDEADBEEF.
  - Cycle N: ready=001.
  - Cycle N+1: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - Cycle N+2: rf_we=0.
- **Contention under RF_ARB_RR_EN**: req_valid=111 held for 6 cycles (each requester drops valid for one cycle after its grant, then re-asserts). Grants must be 0,1,2,0,1,2. Without the macro, all grants go to 0.
- **r0 write**: rd=0, data=0x1234 with valid. Ready is given, rf_we stays 0, busy_vec is unchanged.
- **Scoreboard lifecycle**: resv rd=7 in cycle 0.
  - Cycles 1..k: qry_rs=7 gives busy=1.
  - Requester writes rd=7 in cycle k. busy is still 1 in cycle k+1 and 0 in cycle k+2.
- **Set/clear collision**: rf_we to r9 in the same cycle as resv_valid, rd=9. busy_vec[9] remains 1 afterwards.
- **Reset mid-transfer**: assert reset in the cycle after a grant. rf_we=0 immediately (asynchronous), busy_vec=0, and the first grant after release goes to requester 0.
